// File: rtl/issue_queue_int.sv
// Age-ordered integer issue queue with CDB wakeup and oldest-ready selection.
// Define ISSUE_Q_WAKEUP_BYPASS_EN to let same-cycle CDB wakeups count toward readiness.
module issue_queue_int #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned TAG_W  = 6,
    parameter int unsigned DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [3:0]                 disp_op,
    input  logic [TAG_W-1:0]           disp_rd_tag,
    input  logic                       disp_rs1_rdy,
    input  logic                       disp_rs2_rdy,
    input  logic [TAG_W-1:0]           disp_rs1_tag,
    input  logic [TAG_W-1:0]           disp_rs2_tag,
    input  logic [DATA_W-1:0]          disp_rs1_data,
    input  logic [DATA_W-1:0]          disp_rs2_data,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [DATA_W-1:0]          cdb_data,
    input  logic                       flush,
    output logic                       ready_int,
    input  logic                       issue_int,
    output logic                       iss_valid,
    output logic [3:0]                 iss_op,
    output logic [TAG_W-1:0]           iss_rd_tag,
    output logic [DATA_W-1:0]          iss_rs1_data,
    output logic [DATA_W-1:0]          iss_rs2_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = $clog2(DEPTH);

    typedef struct packed {
        logic              valid;
        logic [3:0]        op;
        logic [TAG_W-1:0]  rd_tag;
        logic              rs1_rdy;
        logic [TAG_W-1:0]  rs1_tag;
        logic [DATA_W-1:0] rs1_data;
        logic              rs2_rdy;
        logic [TAG_W-1:0]  rs2_tag;
        logic [DATA_W-1:0] rs2_data;
    } entry_t;

    entry_t        ent_q [DEPTH];
    entry_t        ent_d [DEPTH];
    // Woken view of each entry; the extra top slot is an empty filler for the shift.
    entry_t        wk    [DEPTH+1];
    entry_t        disp_ent;
    logic [DEPTH-1:0] ent_rdy;
    logic [IW-1:0] sel;
    logic [CW-1:0] count_q, count_d, disp_slot;
    logic          do_disp, do_issue;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wk[i] = ent_q[i];
            if (cdb_valid && ent_q[i].valid) begin
                if (!ent_q[i].rs1_rdy && ent_q[i].rs1_tag == cdb_tag) begin
                    wk[i].rs1_rdy  = 1'b1;
                    wk[i].rs1_data = cdb_data;
                end
                if (!ent_q[i].rs2_rdy && ent_q[i].rs2_tag == cdb_tag) begin
                    wk[i].rs2_rdy  = 1'b1;
                    wk[i].rs2_data = cdb_data;
                end
            end
`ifdef ISSUE_Q_WAKEUP_BYPASS_EN
            ent_rdy[i] = wk[i].valid & wk[i].rs1_rdy & wk[i].rs2_rdy;
`else
            ent_rdy[i] = ent_q[i].valid & ent_q[i].rs1_rdy & ent_q[i].rs2_rdy;
`endif
        end
        wk[DEPTH] = '0;
    end

    always_comb begin
        sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_rdy[i]) sel = IW'(i);
        end
    end

    assign ready_int  = |ent_rdy;
    assign disp_ready = count_q < CW'(DEPTH);
    assign do_disp    = disp_valid & disp_ready & ~flush;
    assign do_issue   = issue_int & ready_int & ~flush;
    assign disp_slot  = count_q - CW'(do_issue);
    assign count      = count_q;

    always_comb begin
        disp_ent          = '0;
        disp_ent.valid    = 1'b1;
        disp_ent.op       = disp_op;
        disp_ent.rd_tag   = disp_rd_tag;
        disp_ent.rs1_tag  = disp_rs1_tag;
        disp_ent.rs2_tag  = disp_rs2_tag;
        disp_ent.rs1_rdy  = disp_rs1_rdy | (cdb_valid && cdb_tag == disp_rs1_tag);
        disp_ent.rs2_rdy  = disp_rs2_rdy | (cdb_valid && cdb_tag == disp_rs2_tag);
        disp_ent.rs1_data = disp_rs1_rdy ? disp_rs1_data : cdb_data;
        disp_ent.rs2_data = disp_rs2_rdy ? disp_rs2_data : cdb_data;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = wk[i];
            if (do_issue && IW'(i) >= sel) ent_d[i] = wk[i+1];
            if (do_disp && CW'(i) == disp_slot) ent_d[i] = disp_ent;
            if (flush) ent_d[i] = '0;
        end
        count_d = flush ? '0 : count_q + CW'(do_disp) - CW'(do_issue);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            count_q      <= '0;
            iss_valid    <= 1'b0;
            iss_op       <= '0;
            iss_rd_tag   <= '0;
            iss_rs1_data <= '0;
            iss_rs2_data <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            count_q   <= count_d;
            iss_valid <= do_issue;
            if (do_issue) begin
                iss_op       <= wk[sel].op;
                iss_rd_tag   <= wk[sel].rd_tag;
                iss_rs1_data <= wk[sel].rs1_data;
                iss_rs2_data <= wk[sel].rs2_data;
            end
        end
    end

endmodule
